// File: rtl/tick_timer_ctrl_pkg.sv
// Shared types and default widths/reset values for the tick timer.
package tick_timer_ctrl_pkg;

    // Controller states, 1-bit encoding.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    localparam int unsigned PW_DEFAULT  = 8;
    localparam int unsigned CW_DEFAULT  = 16;
    localparam int unsigned DIV_DEFAULT = 49;
    localparam int unsigned CNT_DEFAULT = 10;

endpackage

// File: rtl/tick_timer_ctrl_prescaler.sv
// Runtime-modulus prescaler: counts 0..div and pulses tick on the terminal value.
module tick_timer_ctrl_prescaler #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] div,
    output logic          tick
);

    logic [PW-1:0] pre;

    // Terminal pulse straight from the register, gated by enable.
    always_comb begin
        tick = en && (pre == div);
    end

    // Prescaler counter; clear has priority, wraps to 0 after reaching div.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == div) ? '0 : pre + PW'(1);
        end
    end

endmodule

// File: rtl/tick_timer_ctrl.sv
// Programmable interval timer: prescaler ticks counted up to a terminal count,
// one-shot or periodic, with shadowed configuration applied at period boundaries.
module tick_timer_ctrl
    import tick_timer_ctrl_pkg::*;
#(
    parameter int unsigned PW      = PW_DEFAULT,
    parameter int unsigned CW      = CW_DEFAULT,
    parameter int unsigned DIV_DEF = DIV_DEFAULT,
    parameter int unsigned CNT_DEF = CNT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [PW-1:0] cfg_div,
    input  logic [CW-1:0] cfg_cnt,
    input  logic          cfg_periodic,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          tick,
    output logic          done,
    output logic          cfg_ack,
    output logic [CW-1:0] count
);

    state_t        state;
    logic [PW-1:0] div_sh;
    logic [CW-1:0] cnt_sh;
    logic          per_sh;
    logic          pend;
    logic [PW-1:0] pend_div;
    logic [CW-1:0] pend_cnt;
    logic          pend_per;

    logic          period_end;
    logic          apply_pend;
    logic [PW-1:0] apply_div;
    logic [CW-1:0] apply_cnt;
    logic          apply_per;
    logic [CW-1:0] idle_cnt;

    // Prescaler held at 0 outside RUN and on abort.
    tick_timer_ctrl_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == StIdle) || stop),
        .en    (state == StRun),
        .div   (div_sh),
        .tick  (tick)
    );

    // Period-end detection and the configuration to apply at a boundary; a
    // write arriving on the boundary cycle itself is the newest and wins.
    always_comb begin
        busy       = (state == StRun);
        period_end = tick && (count == cnt_sh - CW'(1));
        done       = period_end && !stop;
        apply_pend = cfg_wr || pend;
        apply_div  = cfg_wr ? cfg_div      : pend_div;
        apply_cnt  = cfg_wr ? cfg_cnt      : pend_cnt;
        apply_per  = cfg_wr ? cfg_periodic : pend_per;
        idle_cnt   = cfg_wr ? cfg_cnt      : cnt_sh;
    end

    // Controller FSM with shadow/pending registers and the tick counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            div_sh   <= PW'(DIV_DEF);
            cnt_sh   <= CW'(CNT_DEF);
            per_sh   <= 1'b0;
            pend     <= 1'b0;
            pend_div <= '0;
            pend_cnt <= '0;
            pend_per <= 1'b0;
            count    <= '0;
            cfg_ack  <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    count <= '0;
                    if (cfg_wr) begin
                        div_sh  <= cfg_div;
                        cnt_sh  <= cfg_cnt;
                        per_sh  <= cfg_periodic;
                        cfg_ack <= 1'b1;
                    end
                    // A zero terminal count can never complete a period.
                    if (start && (idle_cnt != '0)) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state <= StIdle;
                        count <= '0;
                        pend  <= 1'b0;
                    end else if (done) begin
                        count <= '0;
                        if (apply_pend) begin
                            div_sh  <= apply_div;
                            cnt_sh  <= apply_cnt;
                            per_sh  <= apply_per;
                            pend    <= 1'b0;
                            cfg_ack <= 1'b1;
                        end
                        if (!per_sh || (apply_pend && (apply_cnt == '0))) begin
                            state <= StIdle;
                        end
                    end else begin
                        if (tick) begin
                            count <= count + CW'(1);
                        end
                        if (cfg_wr) begin
                            pend     <= 1'b1;
                            pend_div <= cfg_div;
                            pend_cnt <= cfg_cnt;
                            pend_per <= cfg_periodic;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
